// File: rtl/fitbit_pkg.sv
// Shared encodings for the step-pulse source and the step tracker bench:
// cadence modes, fixed rates, the 9-second hybrid profile and FSM states.
package fitbit_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned RATE_W  = 8;
    localparam int unsigned SEC_W   = 8;
    localparam int unsigned TOTAL_W = 16;

    localparam logic [MODE_W-1:0] MODE_32  = 2'd0;
    localparam logic [MODE_W-1:0] MODE_64  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_128 = 2'd2;
    localparam logic [MODE_W-1:0] MODE_HYB = 2'd3;

    localparam int unsigned RATE_32  = 32;
    localparam int unsigned RATE_64  = 64;
    localparam int unsigned RATE_128 = 128;

    localparam int unsigned HYB_LEN = 9;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Hybrid profile rate for a given elapsed second; zero past the end.
    function automatic logic [RATE_W-1:0] hyb_rate(input logic [SEC_W-1:0] idx);
        case (idx)
            8'd0:    return 8'd20;
            8'd1:    return 8'd33;
            8'd2:    return 8'd66;
            8'd3:    return 8'd27;
            8'd4:    return 8'd70;
            8'd5:    return 8'd30;
            8'd6:    return 8'd19;
            8'd7:    return 8'd30;
            8'd8:    return 8'd33;
            default: return 8'd0;
        endcase
    endfunction

    // Pulses per second for a latched mode at the given elapsed second.
    function automatic logic [RATE_W-1:0] mode_rate(input logic [MODE_W-1:0] m,
                                                    input logic [SEC_W-1:0]  sec);
        case (m)
            MODE_32:  return RATE_W'(RATE_32);
            MODE_64:  return RATE_W'(RATE_64);
            MODE_128: return RATE_W'(RATE_128);
            default:  return hyb_rate(sec);
        endcase
    endfunction

endpackage

// File: rtl/rate_accumulator.sv
// Phase accumulator: adds rate each enabled cycle and emits a registered
// pulse whenever the sum crosses CLK_HZ, giving exactly rate pulses per second.
module rate_accumulator
    import fitbit_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned ACC_W  = $clog2(CLK_HZ + 128)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [RATE_W-1:0] rate,
    output logic              pulse,
    output logic              fire_c
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_c;

    // acc < CLK_HZ and rate <= 128, so the sum never overflows ACC_W.
    always_comb begin
        sum_c  = acc + ACC_W'(rate);
        fire_c = en && (sum_c >= ACC_W'(CLK_HZ));
    end

    // clr wins over the accumulate but not over the pulse compare, so a
    // second-boundary clear still emits the pulse due on that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= fire_c;
            if (clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= fire_c ? (sum_c - ACC_W'(CLK_HZ)) : sum_c;
            end
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Step-pulse source: fixed-cadence or hybrid-profile single-cycle strobes,
// with elapsed-second and pulse-total reporting.
module step_pulse_gen
    import fitbit_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned ACC_W  = $clog2(CLK_HZ + 128)
) (
    input  logic               clk100Mhz,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [MODE_W-1:0]  mode,
    output logic               pulseSignal,
    output logic               busy,
    output logic               done,
    output logic [SEC_W-1:0]   sec_count,
    output logic [TOTAL_W-1:0] pulse_total
);

    localparam int unsigned TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);

    logic [0:0]         state, state_nxt;
    logic [MODE_W-1:0]  mode_q, mode_nxt;
    logic [TICK_W-1:0]  tick, tick_nxt;
    logic [SEC_W-1:0]   sec_nxt;
    logic [TOTAL_W-1:0] total_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               acc_clr_c;
    logic               acc_en_c;
    logic               fire_c;
    logic [RATE_W-1:0]  rate_c;

    assign rate_c = mode_rate(mode_q, sec_count);

    rate_accumulator #(
        .CLK_HZ (CLK_HZ),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk    (clk100Mhz),
        .rst    (rst),
        .clr    (acc_clr_c),
        .en     (acc_en_c),
        .rate   (rate_c),
        .pulse  (pulseSignal),
        .fire_c (fire_c)
    );

    // State and counter registers.
    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= '0;
            tick        <= '0;
            sec_count   <= '0;
            pulse_total <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode_q      <= mode_nxt;
            tick        <= tick_nxt;
            sec_count   <= sec_nxt;
            pulse_total <= total_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state, counter and accumulator control.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        tick_nxt  = tick;
        sec_nxt   = sec_count;
        total_nxt = pulse_total;
        done_nxt  = 1'b0;
        acc_clr_c = 1'b0;
        acc_en_c  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                    mode_nxt  = mode;
                    tick_nxt  = '0;
                    sec_nxt   = '0;
                    total_nxt = '0;
                    acc_clr_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    acc_clr_c = 1'b1;
                end else begin
                    acc_en_c = 1'b1;
                    if (fire_c && (pulse_total != '1)) begin
                        total_nxt = pulse_total + TOTAL_W'(1);
                    end
                    if (tick == TICK_LAST) begin
                        tick_nxt  = '0;
                        acc_clr_c = 1'b1;
                        if (sec_count != '1) begin
                            sec_nxt = sec_count + SEC_W'(1);
                        end
                        // Last second of the hybrid profile just ended.
                        if ((mode_q == MODE_HYB) && (sec_count == SEC_W'(HYB_LEN - 1))) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        tick_nxt = tick + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_RUN);
    end

endmodule
